// File: rtl/ieee754_div.sv
// ieee754_div: sequential IEEE-754 single-precision divider, y = a / b.
// A restoring mantissa divider resolves ITER_PER_CYCLE quotient bits per clock.
// The quotient mantissa is truncated, and denormal operands or results are
// flushed to zero.
//
// Ports:
//   clock        rising-edge clock
//   resetn       asynchronous, active-low reset
//   start        request; a and b are sampled on an edge where ready=1
//   a, b         dividend / divisor (IEEE-754 single)
//   ready        high while IDLE
//   done         one-cycle pulse; y and div_by_zero are valid from this cycle
//   y            quotient; holds its value until the next done
//   div_by_zero  status of the last result
//   dbg_state    current FSM state (0 IDLE, 1 DIV, 2 NORM, 3 SPECIAL)
//
// Handshake: a request is accepted on a rising edge where start=1 and ready=1.
// A start seen while ready=0 is ignored. Each accepted request produces exactly
// one done pulse, unless a reset aborts it. ready rises in the done cycle, so a
// start in that cycle is accepted back-to-back.
module ieee754_div #(
   parameter int ITER_PER_CYCLE = 1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        ready,
   output logic        done,
   output logic [31:0] y,
   output logic        div_by_zero,
   output logic [1:0]  dbg_state
);

   if (ITER_PER_CYCLE != 1 && ITER_PER_CYCLE != 5 && ITER_PER_CYCLE != 25) begin : g_bad_cfg
      $error("ieee754_div: ITER_PER_CYCLE must be 1, 5 or 25");
   end

   localparam int         NCYC = 25 / ITER_PER_CYCLE;
   localparam logic [4:0] LAST = 5'(NCYC - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, NORM = 2'd2, SPECIAL = 2'd3} state_t;

   state_t      state;
   logic        sign;
   logic [7:0]  ea, eb;
   logic [23:0] mb;
   logic [24:0] r, r_n;
   logic [24:0] q, q_n;
   logic [4:0]  cnt;

   logic              is_special;
   logic signed [9:0] e_norm;
   logic [22:0]       mant;
   logic [31:0]       norm_y;
   logic [31:0]       spec_y;
   logic              spec_dz;

   assign dbg_state = state;

   // Any reserved exponent (0 or 255) on either operand skips the divider.
   assign is_special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) ||
                       (a[30:23] == 8'h00) || (b[30:23] == 8'h00);

   // ITER_PER_CYCLE restoring steps. The remainder stays below 2*mb < 2^25,
   // so the bit shifted out of r is always zero.
   always_comb begin
      r_n = r;
      q_n = q;
      for (int i = 0; i < ITER_PER_CYCLE; i++) begin
         if (r_n >= {1'b0, mb}) begin
            r_n = r_n - {1'b0, mb};
            q_n = {q_n[23:0], 1'b1};
         end else begin
            q_n = {q_n[23:0], 1'b0};
         end
         r_n = r_n << 1;
      end
   end

   // q holds floor(ma/mb * 2^24). q[24] tells whether the mantissa ratio
   // reached 1.0, which selects both the mantissa window and the exponent bias.
   always_comb begin
      if (q[24]) begin
         mant   = q[23:1];
         e_norm = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
      end else begin
         mant   = q[22:0];
         e_norm = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
      end
      if (e_norm >= 10'sd255) begin
         norm_y = {sign, 8'hFF, 23'h0};
      end else if (e_norm <= 10'sd0) begin
         norm_y = {sign, 31'h0};
      end else begin
         norm_y = {sign, e_norm[7:0], mant};
      end
   end

   // Special cases are listed in priority order.
   always_comb begin
      spec_dz = 1'b0;
      if (ea == 8'hFF || eb == 8'hFF) begin
         spec_y = 32'h7FC0_0000;
      end else if (eb == 8'h00 && ea == 8'h00) begin
         spec_y  = 32'h7FC0_0000;
         spec_dz = 1'b1;
      end else if (eb == 8'h00) begin
         spec_y  = {sign, 8'hFF, 23'h0};
         spec_dz = 1'b1;
      end else begin
         spec_y = {sign, 31'h0};
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         ready       <= 1'b1;
         done        <= 1'b0;
         y           <= 32'h0;
         div_by_zero <= 1'b0;
         sign        <= 1'b0;
         ea          <= 8'h0;
         eb          <= 8'h0;
         mb          <= 24'h0;
         r           <= 25'h0;
         q           <= 25'h0;
         cnt         <= 5'h0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sign  <= a[31] ^ b[31];
                  ea    <= a[30:23];
                  eb    <= b[30:23];
                  mb    <= {1'b1, b[22:0]};
                  r     <= {2'b01, a[22:0]};
                  q     <= 25'h0;
                  cnt   <= 5'h0;
                  ready <= 1'b0;
                  state <= is_special ? SPECIAL : DIV;
               end
            end
            DIV: begin
               r <= r_n;
               q <= q_n;
               if (cnt == LAST) begin
                  state <= NORM;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            NORM: begin
               y           <= norm_y;
               div_by_zero <= 1'b0;
               done        <= 1'b1;
               ready       <= 1'b1;
               state       <= IDLE;
            end
            SPECIAL: begin
               y           <= spec_y;
               div_by_zero <= spec_dz;
               done        <= 1'b1;
               ready       <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
